// File: rtl/movement_cmd_pkg.sv
// Shared definitions for the movement command receiver: ASCII command codes,
// UART receiver states, one-hot motion encoding and the command decoder.
package movement_cmd_pkg;

    localparam logic [7:0] CMD_F_UC = 8'h46;
    localparam logic [7:0] CMD_F_LC = 8'h66;
    localparam logic [7:0] CMD_B_UC = 8'h42;
    localparam logic [7:0] CMD_B_LC = 8'h62;
    localparam logic [7:0] CMD_L_UC = 8'h4C;
    localparam logic [7:0] CMD_L_LC = 8'h6C;
    localparam logic [7:0] CMD_R_UC = 8'h52;
    localparam logic [7:0] CMD_R_LC = 8'h72;
    localparam logic [7:0] CMD_S_UC = 8'h53;
    localparam logic [7:0] CMD_S_LC = 8'h73;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Bit order matches {fwd, bwd, left, right, stop}.
    typedef enum logic [4:0] {
        MOT_FWD   = 5'b10000,
        MOT_BWD   = 5'b01000,
        MOT_LEFT  = 5'b00100,
        MOT_RIGHT = 5'b00010,
        MOT_STOP  = 5'b00001
    } motion_e;

    typedef struct packed {
        logic    valid;
        motion_e motion;
    } cmd_decode_t;

    function automatic cmd_decode_t decode_cmd(input logic [7:0] b);
        cmd_decode_t r;
        r = '{valid: 1'b1, motion: MOT_STOP};
        case (b)
            CMD_F_UC, CMD_F_LC: r.motion = MOT_FWD;
            CMD_B_UC, CMD_B_LC: r.motion = MOT_BWD;
            CMD_L_UC, CMD_L_LC: r.motion = MOT_LEFT;
            CMD_R_UC, CMD_R_LC: r.motion = MOT_RIGHT;
            CMD_S_UC, CMD_S_LC: r.motion = MOT_STOP;
            default:            r.valid  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, baud counter and RX state machine.
// byte_valid / frame_err are single-cycle strobes in the stop-bit sample cycle.
module uart_rx_core
    import movement_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_sample;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d    = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= rx_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    assign stop_sample = (state_q == RX_STOP) && (baud_q == BIT_LAST);
    assign rx_byte     = shift_q;
    assign byte_valid  = stop_sample && sync2_q;
    assign frame_err   = stop_sample && !sync2_q;

endmodule

// File: rtl/movement_cmd_rx.sv
// Movement command front-end: decodes UART command bytes into held one-hot
// motion levels, with a watchdog that forces stop when commands cease.
module movement_cmd_rx
    import movement_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic fwd_out,
    output logic bwd_out,
    output logic left_out,
    output logic right_out,
    output logic stop_out,
    output logic cmd_valid,
    output logic frame_err,
    output logic timed_out
);

    localparam bit            WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam int            WW      = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WD_EN ? WW'(TIMEOUT_CYCLES - 1) : '0;

    logic        [7:0] rx_byte;
    logic              byte_valid, byte_err;
    cmd_decode_t       dec;
    logic              cmd_hit, wd_expire;

    motion_e     motion_q, motion_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        timed_out_q, timed_out_d;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (byte_err)
    );

    // A command arriving in the expiry cycle takes priority over the forced stop.
    always_comb begin
        dec         = decode_cmd(rx_byte);
        cmd_hit     = byte_valid && dec.valid;
        wd_expire   = WD_EN && (motion_q != MOT_STOP) && (wd_cnt_q == WD_LAST);
        motion_d    = motion_q;
        wd_cnt_d    = wd_cnt_q;
        timed_out_d = timed_out_q;
        cmd_valid_d = cmd_hit;
        frame_err_d = byte_err;
        if (cmd_hit) begin
            motion_d    = dec.motion;
            wd_cnt_d    = '0;
            timed_out_d = 1'b0;
        end else if (wd_expire) begin
            motion_d    = MOT_STOP;
            timed_out_d = 1'b1;
        end else if (WD_EN && motion_q != MOT_STOP) begin
            wd_cnt_d = wd_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motion_q    <= MOT_STOP;
            wd_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            motion_q    <= motion_d;
            wd_cnt_q    <= wd_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign {fwd_out, bwd_out, left_out, right_out, stop_out} = motion_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_movement_cmd_rx.sv
// Randomised bench for movement_cmd_rx against a deadline-based command model.
module tb_movement_cmd_rx;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_in = 1'b1;
    logic fwd_out, bwd_out, left_out, right_out, stop_out;
    logic cmd_valid, frame_err, timed_out;

    movement_cmd_rx #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (rx_in),
        .fwd_out  (fwd_out),
        .bwd_out  (bwd_out),
        .left_out (left_out),
        .right_out(right_out),
        .stop_out (stop_out),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_motion();
        case ({fwd_out, bwd_out, left_out, right_out, stop_out})
            5'b10000: return "F";
            5'b01000: return "B";
            5'b00100: return "L";
            5'b00010: return "R";
            5'b00001: return "S";
            default:  return "?";
        endcase
    endfunction

    // Passive monitor: counts negedges and output pulses.
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         last_pulse_cyc = -1;
    logic [7:0] prev_motion = "S";
    logic [7:0] motion_before_pulse = "S";
    bit         onehot_bad = 1'b0;
    bit         to_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (dut_motion() == "?") onehot_bad = 1'b1;
        if (timed_out) to_seen = 1'b1;
        if (cmd_valid) begin
            n_valid++;
            last_pulse_cyc      = cyc;
            motion_before_pulse = prev_motion;
        end
        if (frame_err) n_ferr++;
        prev_motion = dut_motion();
    end

    // Reference model: last recognised command plus the cycle it took effect.
    logic [7:0] exp_motion = "S";
    bit         exp_to = 1'b0;
    int         exp_start = 0;

    function automatic logic [7:0] ref_decode(input logic [7:0] b);
        logic [7:0] u;
        u = b & 8'hDF;
        if (u inside {"F", "B", "L", "R", "S"}) return u;
        return 8'h00;
    endfunction

    function automatic bit expired_at(input int c);
        return (exp_motion != "S") && (c >= exp_start + TMO);
    endfunction

    function automatic logic [7:0] exp_motion_at(input int c);
        return expired_at(c) ? 8'("S") : exp_motion;
    endfunction

    function automatic bit exp_to_at(input int c);
        return expired_at(c) ? 1'b1 : exp_to;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input string tag, input int target);
        if (target <= cyc) check({tag, ":target_in_past"}, 32'(cyc), 32'(target - 1));
        while (cyc < target) tick(1);
    endtask

    task automatic check_state(input string tag);
        check({tag, ":motion"}, dut_motion(), exp_motion_at(cyc));
        check({tag, ":timed_out"}, timed_out, exp_to_at(cyc));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits,
                              output int stop_start);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        stop_start = -1;
        for (int i = 0; i < nbits; i++) begin
            rx_in = f[i];
            if (i == 9) stop_start = cyc;
            tick(CPB);
        end
        rx_in = 1'b1;
    endtask

    task automatic send_cmd(input string tag, input logic [7:0] b, input logic stop_bit);
        int         v0, f0, ss, pc;
        logic [7:0] d;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(b, stop_bit, 10, ss);
        tick(CPB);
        d = stop_bit ? ref_decode(b) : 8'h00;
        check({tag, ":cmd_valid_pulses"}, 32'(n_valid - v0), 32'(d != 8'h00));
        check({tag, ":frame_err_pulses"}, 32'(n_ferr - f0), 32'(!stop_bit));
        if (d != 8'h00) begin
            pc = last_pulse_cyc;
            check({tag, ":pulse_in_stop_bit"}, 32'(pc >= ss && pc <= ss + CPB), 32'd1);
            check({tag, ":level_before_pulse"}, motion_before_pulse, exp_motion_at(pc - 1));
            exp_motion = d;
            exp_to     = 1'b0;
            exp_start  = pc;
        end
        check_state(tag);
    endtask

    initial begin
        int         v0, f0, ss, r;
        logic [7:0] b;
        string      letters;

        letters = "FBLRS";
        tick(3);
        check("reset:fwd", fwd_out, 1'b0);
        check("reset:bwd", bwd_out, 1'b0);
        check("reset:left", left_out, 1'b0);
        check("reset:right", right_out, 1'b0);
        check("reset:stop", stop_out, 1'b1);
        check("reset:cmd_valid", cmd_valid, 1'b0);
        check("reset:frame_err", frame_err, 1'b0);
        check("reset:timed_out", timed_out, 1'b0);
        rst_n = 1'b1;
        tick(2 * CPB);

        // Basic forward then lowercase stop.
        send_cmd("t1_F", 8'h46, 1'b1);
        send_cmd("t1_s", 8'h73, 1'b1);

        // Watchdog expiry boundary, then recovery.
        send_cmd("t2_R", 8'h52, 1'b1);
        wait_to("t2", exp_start + TMO - 1);
        check("t2:right_before_expiry", right_out, 1'b1);
        check("t2:to_before_expiry", timed_out, 1'b0);
        tick(1);
        check("t2:right_after_expiry", right_out, 1'b0);
        check("t2:stop_after_expiry", stop_out, 1'b1);
        check("t2:to_after_expiry", timed_out, 1'b1);
        send_cmd("t2_l", 8'h6C, 1'b1);

        // Refreshing within the window keeps motion and never times out.
        to_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_cmd("t3_L", 8'h4C, 1'b1);
            tick(900 - 11 * CPB);
        end
        check("t3:timed_out_seen", to_seen, 1'b0);
        check_state("t3_end");

        // Bad stop bit and unknown byte leave levels alone.
        send_cmd("t4_B_badstop", 8'h42, 1'b0);
        send_cmd("t4_X", 8'h58, 1'b1);

        // Short low glitch on idle line.
        v0 = n_valid;
        f0 = n_ferr;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(3 * CPB);
        check("t5:glitch_cmd_valid", 32'(n_valid - v0), 32'd0);
        check("t5:glitch_frame_err", 32'(n_ferr - f0), 32'd0);
        send_cmd("t5_F_after_glitch", 8'h46, 1'b1);

        // Line stuck low: one framing error, then no retrigger.
        v0 = n_valid;
        f0 = n_ferr;
        rx_in = 1'b0;
        tick(30 * CPB);
        check("stuck:frame_err", 32'(n_ferr - f0), 32'd1);
        check("stuck:cmd_valid", 32'(n_valid - v0), 32'd0);
        rx_in = 1'b1;
        tick(2 * CPB);
        check_state("stuck_end");

        // Reset during the data bits of a frame.
        send_cmd("t6_F", 8'h46, 1'b1);
        send_frame(8'h42, 1'b1, 4, ss);
        rst_n = 1'b0;
        #1;
        check("t6:async_fwd", fwd_out, 1'b0);
        check("t6:async_stop", stop_out, 1'b1);
        check("t6:async_timed_out", timed_out, 1'b0);
        exp_motion = "S";
        exp_to     = 1'b0;
        rx_in      = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * CPB);
        check_state("t6_after_reset");
        send_cmd("t6_B", 8'h42, 1'b1);

        // Randomised traffic, including repeats, junk bytes and long gaps.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                b = letters[$urandom_range(0, 4)];
                if ($urandom_range(0, 1) == 1) b = b | 8'h20;
            end else begin
                b = 8'($urandom);
            end
            send_cmd($sformatf("rand%0d_%02h", i, b), b, ($urandom_range(0, 9) != 0));
            tick(($urandom_range(0, 4) == 0) ? $urandom_range(0, 1200) : $urandom_range(0, 300));
            check_state($sformatf("rand%0d_gap", i));
        end

        check("onehot_always", onehot_bad, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
